div_req_arbiter: RTL

Shares one `divider` instance among several synthesizer channels. Each requester presents operands via a valid/ready handshake. The block arbitrates round-robin, drives the divider's trigger/ready/done handshake, and returns the quotient and remainder tagged with the channel number. Division by zero and a divider timeout are handled locally, so the divider never stalls the pipeline.

---
 rtl/div_req_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/div_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : div_req_arbiter
// Purpose  : Shares one divider among NUM_CH requesting channels. Grants are
//            issued round-robin. The block drives the divider's
//            trigger/ready/done handshake and returns quotient and remainder
//            tagged with the channel number. Division by zero and a divider
//            timeout are resolved locally.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   ctl_clk, reset               clock and asynchronous active-low reset
//   req_valid/req_a/req_b/req_signed/req_ready
//                                per-channel request handshake (packed buses)
//   res_valid/res_ready/res_ch/res_q/res_r/res_div0/res_err
//                                result handshake and payload
//   div_a/div_b/div_signed/div_trigger/div_ready/div_done/div_q/div_r
//                                connection to the shared divider
// ============================================================================
module div_req_arbiter #(
  parameter int C_WIDTH = 32,
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                       ctl_clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [NUM_CH*C_WIDTH-1:0]  req_a,
  input  logic [NUM_CH*C_WIDTH-1:0]  req_b,
  input  logic [NUM_CH-1:0]          req_signed,
  output logic [NUM_CH-1:0]          req_ready,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [CH_BITS-1:0]         res_ch,
  output logic [C_WIDTH-1:0]         res_q,
  output logic [C_WIDTH-1:0]         res_r,
  output logic                       res_div0,
  output logic                       res_err,
  output logic [C_WIDTH-1:0]         div_a,
  output logic [C_WIDTH-1:0]         div_b,
  output logic                       div_signed,
  output logic                       div_trigger,
  input  logic                       div_ready,
  input  logic                       div_done,
  input  logic [C_WIDTH-1:0]         div_q,
  input  logic [C_WIDTH-1:0]         div_r
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CH_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_BITS-1:0]   ch_q, ch_d;
  logic [C_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [C_WIDTH-1:0]   q_q, q_d, r_q, r_d;
  logic                 signed_q, signed_d;
  logic                 div0_q, div0_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 gnt_found;
  logic [CH_BITS-1:0]   gnt_idx;
  logic [NUM_CH-1:0]    gnt_vec;
  logic [C_WIDTH-1:0]   sel_a, sel_b;
  logic                 sel_signed;

  // Round-robin search. The first loop covers channels below rr_ptr (the
  // wrapped part); the second loop covers rr_ptr and above and overrides it,
  // so the lowest valid channel at or after rr_ptr wins.
  always_comb begin
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_valid[i] && (CH_BITS'(i) < rr_ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_BITS'(i);
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_valid[i] && (CH_BITS'(i) >= rr_ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_BITS'(i);
      end
    end
    gnt_vec    = '0;
    sel_a      = '0;
    sel_b      = '0;
    sel_signed = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_found && (gnt_idx == CH_BITS'(i))) begin
        gnt_vec[i] = 1'b1;
        sel_a      = req_a[i*C_WIDTH +: C_WIDTH];
        sel_b      = req_b[i*C_WIDTH +: C_WIDTH];
        sel_signed = req_signed[i];
      end
    end
  end

  // The grant is combinational, so it is also gated by reset to keep
  // req_ready low while reset is asserted.
  assign req_ready = ((state_q == IDLE) && reset) ? gnt_vec : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    ch_d        = ch_q;
    a_d         = a_q;
    b_d         = b_q;
    signed_d    = signed_q;
    q_d         = q_q;
    r_d         = r_q;
    div0_d      = div0_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    div_trigger = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          ch_d     = gnt_idx;
          a_d      = sel_a;
          b_d      = sel_b;
          signed_d = sel_signed;
          rr_ptr_d = (gnt_idx == CH_BITS'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
          div0_d   = 1'b0;
          err_d    = 1'b0;
          if (sel_b == '0) begin
            // Divide by zero never reaches the divider.
            q_d     = '1;
            r_d     = sel_a;
            div0_d  = 1'b1;
            state_d = RESULT;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (div_ready) begin
          div_trigger = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (div_done) begin
          q_d     = div_q;
          r_d     = div_r;
          state_d = RESULT;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          q_d     = '0;
          r_d     = '0;
          err_d   = 1'b1;
          state_d = RESULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESULT: begin
        if (res_ready) begin
          div0_d  = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      ch_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      q_q      <= '0;
      r_q      <= '0;
      div0_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      ch_q     <= ch_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      q_q      <= q_d;
      r_q      <= r_d;
      div0_q   <= div0_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Latched operands feed the divider directly; they only change on a new
  // grant, so they stay stable through ISSUE and WAIT.
  assign div_a      = a_q;
  assign div_b      = b_q;
  assign div_signed = signed_q;

  assign res_valid  = (state_q == RESULT);
  assign res_ch     = ch_q;
  assign res_q      = q_q;
  assign res_r      = r_q;
  assign res_div0   = div0_q;
  assign res_err    = err_q;

endmodule
`default_nettype wire
